// File: rtl/alu_pipe_if.sv
// ============================================================================
//  Module      : alu_pipe_if
//  Description : Operand/result handshake bundle for alu_pipe.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface alu_pipe_if #(
    parameter int WIDTH = 4
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             use_carry;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [3:0]       flags;

    modport master (
        output in_valid, a, b, op, use_carry, out_ready,
        input  in_ready, out_valid, result, flags
    );

    modport slave (
        input  in_valid, a, b, op, use_carry, out_ready,
        output in_ready, out_valid, result, flags
    );
endinterface

`default_nettype wire

// File: rtl/alu_pipe.sv
// ============================================================================
//  Module      : alu_pipe
//  Description : Two-stage pipelined ALU with valid/ready handshake, Z/N/C/V
//                flags and a sticky carry for multi-word chaining.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module alu_pipe #(
    parameter int WIDTH = 4
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    alu_pipe_if.slave   bus
);

    localparam logic [2:0] c_OP_ADD  = 3'b000;
    localparam logic [2:0] c_OP_SUB  = 3'b001;
    localparam logic [2:0] c_OP_INC  = 3'b010;
    localparam logic [2:0] c_OP_PASS = 3'b011;
    localparam logic [2:0] c_OP_AND  = 3'b100;
    localparam logic [2:0] c_OP_OR   = 3'b101;
    localparam logic [2:0] c_OP_XOR  = 3'b110;
    localparam logic [2:0] c_OP_NOT  = 3'b111;

    localparam logic [WIDTH-1:0] c_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam int               c_MSB = WIDTH - 1;

    // Stage-1 operand register
    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic [2:0]       r_s1_op;
    logic             r_s1_uc;

    // Stage-2 result register and sticky carry
    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic [3:0]       r_flags;
    logic             r_carry;

    logic             w_s2_load;
    logic             w_in_ready;
    logic             w_accept;

    logic [WIDTH-1:0] w_addend;
    logic             w_cin;
    logic             w_is_arith;
    logic [WIDTH-1:0] w_logic;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_r;
    logic             w_c;
    logic             w_v;
    logic             w_z;
    logic             w_n;

    // Stage 2 can load when empty or draining this cycle; stage 1 likewise.
    assign w_s2_load  = r_s1_valid && (!r_out_valid || bus.out_ready);
    assign w_in_ready = !r_s1_valid || w_s2_load;
    assign w_accept   = bus.in_valid && w_in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_op    <= '0;
            r_s1_uc    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_s1_valid <= 1'b1;
                r_s1_a     <= bus.a;
                r_s1_b     <= bus.b;
                r_s1_op    <= bus.op;
                r_s1_uc    <= bus.use_carry;
            end else if (w_s2_load) begin
                r_s1_valid <= 1'b0;
            end
        end
    end

    // SUB is a + ~b + cin, so one adder and one overflow rule cover ADD/SUB/INC.
    always_comb begin
        w_addend   = r_s1_b;
        w_cin      = 1'b0;
        w_is_arith = 1'b0;
        w_logic    = r_s1_a;
        case (r_s1_op)
            c_OP_ADD: begin
                w_addend   = r_s1_b;
                w_cin      = r_s1_uc ? r_carry : 1'b0;
                w_is_arith = 1'b1;
            end
            c_OP_SUB: begin
                w_addend   = ~r_s1_b;
                w_cin      = r_s1_uc ? r_carry : 1'b1;
                w_is_arith = 1'b1;
            end
            c_OP_INC: begin
                w_addend   = c_ONE;
                w_cin      = 1'b0;
                w_is_arith = 1'b1;
            end
            c_OP_PASS: w_logic = r_s1_a;
            c_OP_AND:  w_logic = r_s1_a & r_s1_b;
            c_OP_OR:   w_logic = r_s1_a | r_s1_b;
            c_OP_XOR:  w_logic = r_s1_a ^ r_s1_b;
            c_OP_NOT:  w_logic = ~r_s1_a;
            default:   w_logic = r_s1_a;
        endcase
    end

    assign w_sum = {1'b0, r_s1_a} + {1'b0, w_addend} + {{WIDTH{1'b0}}, w_cin};
    assign w_r   = w_is_arith ? w_sum[WIDTH-1:0] : w_logic;
    assign w_c   = w_is_arith & w_sum[WIDTH];
    assign w_v   = w_is_arith & (r_s1_a[c_MSB] == w_addend[c_MSB])
                              & (w_r[c_MSB] != r_s1_a[c_MSB]);
    assign w_z   = (w_r == '0);
    assign w_n   = w_r[c_MSB];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_flags     <= 4'b0000;
            r_carry     <= 1'b0;
        end else begin
            if (w_s2_load) begin
                r_out_valid <= 1'b1;
                r_result    <= w_r;
                r_flags     <= {w_z, w_n, w_c, w_v};
                if (w_is_arith) begin
                    r_carry <= w_c;
                end
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.flags     = r_flags;

endmodule

`default_nettype wire

// File: tb/tb_alu_pipe.sv
// ============================================================================
//  Module      : tb_alu_pipe
//  Description : Directed self-checking bench for alu_pipe at WIDTH = 8.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_alu_pipe;

    localparam int W = 8;

    localparam logic [2:0] ADD  = 3'b000;
    localparam logic [2:0] SUB  = 3'b001;
    localparam logic [2:0] INC  = 3'b010;
    localparam logic [2:0] PASS = 3'b011;
    localparam logic [2:0] AND  = 3'b100;
    localparam logic [2:0] OR   = 3'b101;
    localparam logic [2:0] XOR  = 3'b110;
    localparam logic [2:0] NOT  = 3'b111;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [11:0] q[$];

    alu_pipe_if #(.WIDTH(W)) bus ();

    alu_pipe #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // A beat is recorded when a transfer will occur on the next rising edge.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready)
            q.push_back({bus.result, bus.flags});
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic uc);
        logic rdy;
        bit   done;
        done          = 1'b0;
        bus.in_valid  = 1'b1;
        bus.op        = op;
        bus.a         = a;
        bus.b         = b;
        bus.use_carry = uc;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            rdy = bus.in_ready;
            @(posedge clk);
            #1;
            done = rdy;
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $error("FAIL push_timeout: observed no accept expected accept");
        end
    endtask

    task automatic idle();
        bus.in_valid  = 1'b0;
        bus.a         = 8'($urandom);
        bus.b         = 8'($urandom);
        bus.op        = 3'($urandom);
        bus.use_carry = 1'($urandom);
    endtask

    task automatic expect_beat(input string tag, input logic [7:0] er, input logic [3:0] ef);
        logic [11:0] e;
        int          n;
        n = 0;
        while (q.size() == 0 && n < 50) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (q.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL %s_timeout: observed no beat expected beat", tag);
        end else begin
            e = q.pop_front();
            check({tag, "_res"},   32'(e[11:4]), 32'(er));
            check({tag, "_flags"}, 32'(e[3:0]),  32'(ef));
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.out_ready = 1'b1;
        idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_result",    32'(bus.result),    32'd0);
        check("rst_flags",     32'(bus.flags),     32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: ADD wrap-around and latency
        push(ADD, 8'hFF, 8'h01, 1'b0);
        idle();
        @(negedge clk);
        check("lat_cycle1", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        check("lat_cycle2", 32'(bus.out_valid), 32'd1);
        expect_beat("add_ff_01", 8'h00, 4'b1010);

        // 2: subtraction with and without borrow
        push(SUB, 8'h03, 8'h08, 1'b0);
        push(SUB, 8'h05, 8'h05, 1'b0);
        idle();
        expect_beat("sub_03_08", 8'hFB, 4'b0100);
        expect_beat("sub_05_05", 8'h00, 4'b1010);

        // 3: overflow and carry chaining, with an AND between a chained pair
        push(ADD, 8'h7F, 8'h01, 1'b0);
        push(ADD, 8'hFF, 8'h01, 1'b0);
        push(ADD, 8'h00, 8'h00, 1'b1);
        push(ADD, 8'hFF, 8'h01, 1'b0);
        push(AND, 8'hA5, 8'h3C, 1'b0);
        push(ADD, 8'h00, 8'h00, 1'b1);
        idle();
        expect_beat("add_ovf",     8'h80, 4'b0101);
        expect_beat("chain1_lo",   8'h00, 4'b1010);
        expect_beat("chain1_hi",   8'h01, 4'b0000);
        expect_beat("chain2_lo",   8'h00, 4'b1010);
        expect_beat("chain2_and",  8'h24, 4'b0000);
        expect_beat("chain2_hi",   8'h01, 4'b0000);

        // 4: logic, transfer and increment
        push(AND,  8'hA5, 8'h3C, 1'b0);
        push(OR,   8'hA5, 8'h3C, 1'b1);
        push(XOR,  8'hA5, 8'h3C, 1'b0);
        push(NOT,  8'hA5, 8'hFF, 1'b0);
        push(PASS, 8'hA5, 8'h3C, 1'b1);
        push(INC,  8'hFF, 8'h55, 1'b0);
        idle();
        expect_beat("and",  8'h24, 4'b0000);
        expect_beat("or",   8'hBD, 4'b0100);
        expect_beat("xor",  8'h99, 4'b0100);
        expect_beat("not",  8'h5A, 4'b0000);
        expect_beat("pass", 8'hA5, 4'b0100);
        expect_beat("inc",  8'h00, 4'b1010);

        // 5: backpressure, capacity of two beats
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        push(ADD, 8'h10, 8'h01, 1'b0);
        push(SUB, 8'h01, 8'h02, 1'b0);
        bus.in_valid = 1'b1;
        bus.op       = XOR;
        bus.a        = 8'hF0;
        bus.b        = 8'h0F;
        @(negedge clk);
        check("bp_in_ready",  32'(bus.in_ready),  32'd0);
        check("bp_out_valid", 32'(bus.out_valid), 32'd1);
        check("bp_result",    32'(bus.result),    32'h11);
        repeat (3) @(negedge clk);
        check("bp_in_ready_hold", 32'(bus.in_ready), 32'd0);
        check("bp_result_hold",   32'(bus.result),   32'h11);
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        push(XOR, 8'hF0, 8'h0F, 1'b0);
        idle();
        expect_beat("bp_beat1", 8'h11, 4'b0000);
        expect_beat("bp_beat2", 8'hFF, 4'b0100);
        expect_beat("bp_beat3", 8'hFF, 4'b0100);
        repeat (5) @(posedge clk);
        #2;
        check("bp_no_dup", 32'(q.size()), 32'd0);

        // 6: reset mid-stream clears pipeline and sticky carry
        push(ADD, 8'hFF, 8'h01, 1'b0);
        idle();
        expect_beat("pre_rst_carry", 8'h00, 4'b1010);
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        push(ADD, 8'h01, 8'h01, 1'b0);
        push(ADD, 8'h02, 8'h02, 1'b0);
        idle();
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_flags",     32'(bus.flags),     32'd0);
        check("mid_rst_result",    32'(bus.result),    32'd0);
        check("mid_rst_in_ready",  32'(bus.in_ready),  32'd1);
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        check("mid_rst_no_stale", 32'(q.size()), 32'd0);
        push(ADD, 8'h00, 8'h00, 1'b1);
        idle();
        expect_beat("post_rst_sticky", 8'h00, 4'b1000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_pipe.md
# alu_pipe

- Parametrised, pipelined successor to the team's 4-bit combinational arithmetic/logic extender, with a registered two-stage datapath.
- Keeps the same eight-operation set (add, subtract, increment, transfer, AND, OR, XOR, NOT) and adds a valid/ready handshake on both sides.
- Adds a registered Z/N/C/V flag set and a sticky carry register for multi-word add/subtract chaining.
- Sits between the DSP operand sequencer (upstream) and the writeback buffer (downstream).

## Interface
Reset is synchronous and active-low on a single clock; the clock and reset ports are `clk` and `rst_n`.

Parameters:
- WIDTH, 4, operand/result width in bits; legal values 2..32.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block can accept a beat this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B; ignored for INC, PASS and NOT
- op  in  3  operation code:
  - 000 ADD, 001 SUB, 010 INC, 011 PASS A
  - 100 AND, 101 OR, 110 XOR, 111 NOT A
- use_carry  in  1  for ADD/SUB only: replace the default carry-in with the sticky carry register
- out_valid  out  1  result beat valid
- out_ready  in  1  downstream accepts the result
- result  out  WIDTH  operation result
- flags  out  4  {Z, N, C, V}, aligned with result

## Operation
Stage 1 (operand register):
- Loads {a, b, op, use_carry} on in_valid && in_ready.
- Sets s1_valid.

Stage 2 (result register):
- Computes from the stage-1 contents and loads result, flags and out_valid.
- Load condition s2_load = s1_valid && (!out_valid || out_ready).

Handshake:
- in_ready = !s1_valid || s2_load. This is a combinational path from out_ready; it is intentional.
- A beat transfers out on out_valid && out_ready.
- Ordering is strictly in-order; no beat is dropped or duplicated.
- result and flags hold stable while out_valid && !out_ready.

Arithmetic, computed at WIDTH+1 bits; cin is the carry-in:
- ADD: {cout, r} = a + b + cin.
  - cin = 0, or the sticky carry register when use_carry = 1.
- SUB: {cout, r} = a + ~b + cin.
  - cin = 1, or the sticky carry register when use_carry = 1.
  - C = 1 means no borrow.
- INC: {cout, r} = a + 1.
- V = signed overflow:
  - ADD and INC: sign(a) == sign(addend) && sign(r) != sign(a).
  - SUB: sign(a) != sign(b) && sign(r) != sign(a).

Logic and transfer:
- PASS returns a; AND, OR, XOR are bitwise; NOT returns ~a.
- C = 0 and V = 0 for all four logic ops and for PASS.

Flags:
- Z = (r == 0); N = r[WIDTH-1].

Sticky carry register:
- Updated with cout on each s2_load of ADD, SUB or INC.
- Unchanged by logic and PASS ops.
- Because updates happen at stage-2 load, in program order, back-to-back chained operations need no stall.

## Timing
- Latency: a beat accepted in cycle t appears with out_valid in cycle t+2 when out_ready stays high.
- Throughput: one beat per cycle.
- Capacity: two beats in flight. With out_ready held low, in_ready falls after two accepted beats.
- Simultaneous accept and drain in the same cycle is legal at both stages.
- Reset values: s1_valid = 0, out_valid = 0, result = 0, flags = 4'b0000, sticky carry = 0. in_ready is 1 during and after reset.
- Reset mid-operation: all in-flight beats are discarded; none appears after rst_n rises.
- Inputs are sampled only on accept; values on a, b and op while in_valid = 0 have no effect.

## Test plan
All scenarios use WIDTH = 8.
1. ADD a = 0xFF, b = 0x01 -> result 0x00, flags Z=1 N=0 C=1 V=0, out_valid exactly 2 cycles after accept.
2. SUB a = 0x03, b = 0x08 -> result 0xFB, Z=0 N=1 C=0 V=0. Then SUB 0x05 - 0x05 -> 0x00, Z=1 C=1.
3. Overflow and chaining:
   - ADD 0x7F + 0x01 -> 0x80, N=1 V=1 C=0.
   - ADD 0xFF + 0x01, then back-to-back ADD use_carry=1 with 0x00 + 0x00 -> second result 0x01, C=0.
   - An AND placed between the two chained adds must not alter the chained result.
4. Logic and unary ops, a = 0xA5, b = 0x3C:
   - AND -> 0x24; OR -> 0xBD; XOR -> 0x99; NOT -> 0x5A; PASS -> 0xA5; INC 0xFF -> 0x00 with C=1.
   - C = 0 and V = 0 for every logic op and PASS.
5. Backpressure:
   - Hold out_ready = 0 and present 3 beats -> only 2 accepted, in_ready = 0, result held stable.
   - Raise out_ready -> all 3 results emerge in order with no gaps or duplicates.
6. Reset mid-stream: accept 2 beats, then pulse rst_n low for 1 cycle -> out_valid = 0, flags = 0, sticky carry = 0, and no stale result afterwards.
